// File: rtl/set_key_ctrl.sv
// Turns the active-low AH/AM set keys into single-cycle hour/minute increment pulses for the time or alarm datapath.
// Optional build macro: AUTO_REPEAT_EN enables hold-to-auto-repeat; when undefined each press yields exactly one pulse.
module set_key_ctrl #(
  parameter int unsigned DB_CYC   = 1_000_000,
  parameter int unsigned HOLD_CYC = 40_000_000,
  parameter int unsigned REP_CYC  = 10_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic [3:0] state_mode,
  input  logic       AH_key,
  input  logic       AM_key,
  output logic       time_hour_inc,
  output logic       time_min_inc,
  output logic       alarm_hour_inc,
  output logic       alarm_min_inc,
  output logic       key_busy
);

  localparam longint unsigned CNT_SPAN = (64'd1 << CNT_W);

  if (longint'(DB_CYC) > CNT_SPAN || longint'(HOLD_CYC) > CNT_SPAN ||
      longint'(REP_CYC) > CNT_SPAN) begin : g_cfg_check
    $error("set_key_ctrl: CNT_W too narrow for the cycle parameters");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRE   = 3'd1,
    S_HOLD   = 3'd2,
    S_FIRE_R = 3'd3,
    S_LOCK   = 3'd4
  } state_t;

  // Key vectors: bit 1 = AH, bit 0 = AM; 1 = released.
  logic [1:0]       r_sync_p0;
  logic [1:0]       r_sync_p1;
  logic [1:0]       r_deb;
  logic [1:0]       r_deb_d;
  logic [CNT_W-1:0] r_db_cnt [2];

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_own_ah;
  logic [3:0]       r_mode;
  logic             w_fire;
  logic [1:0]       w_press;
  logic             w_rel_own;
  logic             w_all_rel;
  logic             w_mode_chg;

  logic             r_time_hour;
  logic             r_time_min;
  logic             r_alarm_hour;
  logic             r_alarm_min;

  // Stage p0/p1: two-flop synchroniser, then per-key debounce
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_sync_p0   <= 2'b11;
      r_sync_p1   <= 2'b11;
      r_deb       <= 2'b11;
      r_deb_d     <= 2'b11;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync_p0 <= {AH_key, AM_key};
      r_sync_p1 <= r_sync_p0;
      r_deb_d   <= r_deb;
      for (int k = 0; k < 2; k++) begin
        if (r_sync_p1[k] == r_deb[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_deb[k]    <= r_sync_p1[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign w_press    = r_deb_d & ~r_deb;
  assign w_rel_own  = r_own_ah ? r_deb[1] : r_deb[0];
  assign w_all_rel  = &r_deb;
  assign w_mode_chg = (state_mode != r_mode);

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LD  = CNT_W'(REP_CYC - 1);

  logic [CNT_W-1:0] r_timer;
  logic             w_load_hold;
  logic             w_load_rep;

  // Loaded on entry to a firing state, so the firing cycle itself is part of each interval.
  assign w_load_hold = (r_state == S_IDLE) && (|w_press);
  assign w_load_rep  = (r_state == S_HOLD) && (w_state_nxt == S_FIRE_R);

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_load_hold) begin
      r_timer <= HOLD_LD;
    end else if (w_load_rep) begin
      r_timer <= REP_LD;
    end else if (r_timer != '0) begin
      r_timer <= r_timer - CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_own_ah <= 1'b0;
      r_mode   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && (|w_press)) begin
        r_own_ah <= w_press[1];
        r_mode   <= state_mode;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_press) w_state_nxt = S_FIRE;
      end
      S_FIRE: begin
        if (w_mode_chg) begin
          w_state_nxt = S_LOCK;
        end else begin
          w_fire = 1'b1;
`ifdef AUTO_REPEAT_EN
          w_state_nxt = S_HOLD;
`else
          w_state_nxt = S_LOCK;
`endif
        end
      end
`ifdef AUTO_REPEAT_EN
      S_HOLD: begin
        // Release wins over a timeout landing in the same cycle.
        if (w_mode_chg || w_rel_own) begin
          w_state_nxt = S_LOCK;
        end else if (r_timer == '0) begin
          w_state_nxt = S_FIRE_R;
        end
      end
      S_FIRE_R: begin
        if (w_mode_chg) begin
          w_state_nxt = S_LOCK;
        end else begin
          w_fire      = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
`endif
      S_LOCK: begin
        if (w_all_rel) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p2: registered, mode-routed pulse outputs
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_time_hour  <= 1'b0;
      r_time_min   <= 1'b0;
      r_alarm_hour <= 1'b0;
      r_alarm_min  <= 1'b0;
    end else begin
      r_time_hour  <= w_fire &  r_own_ah & (state_mode == 4'd1);
      r_time_min   <= w_fire & ~r_own_ah & (state_mode == 4'd1);
      r_alarm_hour <= w_fire &  r_own_ah & (state_mode == 4'd3);
      r_alarm_min  <= w_fire & ~r_own_ah & (state_mode == 4'd3);
    end
  end

  assign time_hour_inc  = r_time_hour;
  assign time_min_inc   = r_time_min;
  assign alarm_hour_inc = r_alarm_hour;
  assign alarm_min_inc  = r_alarm_min;
  assign key_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_set_key_ctrl.sv
// Directed bench for set_key_ctrl: expected pulses are queued with their cycle when a key is driven
// and matched against every pulse the DUT emits.
module tb_set_key_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int LAT  = DB + 3;

  localparam logic [3:0] C_TM = 4'b0001;
  localparam logic [3:0] C_TH = 4'b0010;
  localparam logic [3:0] C_AM = 4'b0100;
  localparam logic [3:0] C_AH = 4'b1000;

  logic       clk_50M = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] state_mode = 4'd0;
  logic       AH_key = 1'b1;
  logic       AM_key = 1'b1;
  logic       time_hour_inc, time_min_inc, alarm_hour_inc, alarm_min_inc, key_busy;

  set_key_ctrl #(
    .DB_CYC  (DB),
    .HOLD_CYC(HOLD),
    .REP_CYC (REP),
    .CNT_W   (8)
  ) dut (
    .clk_50M       (clk_50M),
    .rst           (rst),
    .state_mode    (state_mode),
    .AH_key        (AH_key),
    .AM_key        (AM_key),
    .time_hour_inc (time_hour_inc),
    .time_min_inc  (time_min_inc),
    .alarm_hour_inc(alarm_hour_inc),
    .alarm_min_inc (alarm_min_inc),
    .key_busy      (key_busy)
  );

  always #10 clk_50M = ~clk_50M;

  int cyc = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  logic busy_seen = 1'b0;

  wire [3:0] w_out = {alarm_hour_inc, alarm_min_inc, time_hour_inc, time_min_inc};

  always @(negedge clk_50M) busy_seen <= busy_seen | key_busy;

  // Every pulse seen must be the next one queued, at the queued cycle.
  always @(negedge clk_50M) begin
    exp_t e;
    if (|w_out) begin
      if (expq.size() > 0) begin
        e = expq.pop_front();
      end else begin
        e.cyc  = -1;
        e.code = 4'b0000;
      end
      checks++;
      assert (cyc === e.cyc && w_out === e.code)
      else begin
        errors++;
        $error("FAIL pulse: got cycle %0d outputs %b, expected cycle %0d outputs %b",
               cyc, w_out, e.cyc, e.code);
      end
      checks++;
      assert ($countones(w_out) <= 1)
      else begin
        errors++;
        $error("FAIL onehot: got outputs %b, expected at most one high", w_out);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic push_exp(input int c, input logic [3:0] code);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    expq.push_back(e);
  endtask

  task automatic drain(input string tag);
    chk(tag, expq.size(), 0);
    expq.delete();
  endtask

  int t0;

  initial begin
    // Reset state
    idle(3);
    chk("rst_outputs", w_out, 0);
    chk("rst_busy", key_busy, 0);
    rst = 1'b0;
    idle(3);
    chk("idle_busy", key_busy, 0);

    // Glitch shorter than the debounce window
    state_mode = 4'd1;
    busy_seen  = 1'b0;
    idle(1);
    AM_key = 1'b0;
    idle(3);
    AM_key = 1'b1;
    idle(20);
    chk("glitch_busy", busy_seen, 0);
    drain("glitch_queue");

    // Single press
    t0 = cyc + 1;
    push_exp(t0 + LAT, C_TM);
    AM_key = 1'b0;
    idle(15);
    AM_key = 1'b1;
    idle(25);
    drain("single_queue");
    chk("single_busy", key_busy, 0);

    // Long hold in alarm-set mode
    state_mode = 4'd3;
    idle(1);
    t0 = cyc + 1;
    push_exp(t0 + LAT, C_AH);
`ifdef AUTO_REPEAT_EN
    for (int k = 0; k < 5; k++) push_exp(t0 + LAT + HOLD + k * REP, C_AH);
`endif
    AH_key = 1'b0;
    idle(60);
    AH_key = 1'b1;
    idle(30);
    drain("repeat_queue");
    chk("repeat_busy", key_busy, 0);

    // Simultaneous press: AH owns, AM ignored until re-pressed
    state_mode = 4'd1;
    idle(1);
    t0 = cyc + 1;
    push_exp(t0 + LAT, C_TH);
    AH_key = 1'b0;
    AM_key = 1'b0;
    idle(10);
    AH_key = 1'b1;
    AM_key = 1'b1;
    idle(20);
    drain("simul_queue");
    t0 = cyc + 1;
    push_exp(t0 + LAT, C_TM);
    AM_key = 1'b0;
    idle(10);
    AM_key = 1'b1;
    idle(20);
    drain("simul_repress_queue");

    // Mode change during a hold locks out further pulses
    t0 = cyc + 1;
    push_exp(t0 + LAT, C_TH);
    AH_key = 1'b0;
    idle(15);
    state_mode = 4'd0;
    idle(25);
    state_mode = 4'd1;
    idle(20);
    chk("modechg_lock_busy", key_busy, 1);
    AH_key = 1'b1;
    idle(20);
    chk("modechg_release_busy", key_busy, 0);
    drain("modechg_queue");
    t0 = cyc + 1;
    push_exp(t0 + LAT, C_TH);
    AH_key = 1'b0;
    idle(10);
    AH_key = 1'b1;
    idle(20);
    drain("modechg_repress_queue");

    // Show-alarm mode: FSM runs, pulses suppressed
    state_mode = 4'd2;
    busy_seen  = 1'b0;
    idle(1);
    AM_key = 1'b0;
    idle(10);
    AM_key = 1'b1;
    idle(20);
    chk("mode2_busy_seen", busy_seen, 1);
    drain("mode2_queue");

    // Reset mid-hold
    state_mode = 4'd1;
    idle(1);
    t0 = cyc + 1;
    push_exp(t0 + LAT, C_TH);
    AH_key = 1'b0;
    idle(10);
    rst    = 1'b1;
    AH_key = 1'b1;
    idle(1);
    chk("midrst_outputs", w_out, 0);
    chk("midrst_busy", key_busy, 0);
    idle(2);
    rst = 1'b0;
    idle(25);
    drain("midrst_queue");
    chk("midrst_after_busy", key_busy, 0);

    // 100-clock hold
    t0 = cyc + 1;
    push_exp(t0 + LAT, C_TM);
`ifdef AUTO_REPEAT_EN
    for (int k = 0; k < 10; k++) push_exp(t0 + LAT + HOLD + k * REP, C_TM);
`endif
    AM_key = 1'b0;
    idle(100);
    AM_key = 1'b1;
    idle(30);
    drain("long_queue");
    chk("long_busy", key_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
